// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: length byte, then 3-byte words, written to a sync port.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [19:0]   wr_data,
    output logic          busy,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output logic [AW:0]   count
);

    localparam int unsigned CW      = AW + 1;
    localparam logic [7:0]  DEPTH_B = 8'(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN,
        S_B0,
        S_B1,
        S_B2,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic            accept;
    logic            last_word;
    logic            ready_d;
    logic            busy_d;
    logic [CW-1:0]   len_q;
    logic [3:0]      b0_q;
    logic [7:0]      b1_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      csum_q;
`endif

    assign accept    = byte_valid && byte_ready;
    assign last_word = (CW'(count + 1'b1) == len_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the next-cycle values of the status outputs
    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_d = S_LEN;
            end
            S_LEN: begin
                if (accept) begin
                    if (byte_in == 8'd0 || byte_in > DEPTH_B) state_d = S_ERR;
                    else                                      state_d = S_B0;
                end
            end
            S_B0: if (accept) state_d = S_B1;
            S_B1: if (accept) state_d = S_B2;
            S_B2: if (accept) state_d = S_WRITE;
            S_WRITE: begin
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_B0;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) state_d = (byte_in == csum_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_LEN) || (state_d == S_B0) ||
                  (state_d == S_B1)  || (state_d == S_B2);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (state_d == S_CSUM) ready_d = 1'b1;
`endif
        busy_d  = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR));
    end

    // Registered outputs and datapath; status flags follow the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            count      <= '0;
            len_q      <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            byte_ready <= ready_d;
            busy       <= busy_d;
            cpu_hold   <= busy_d;
            wr_en      <= (state_d == S_WRITE);
            done       <= (state_d == S_DONE);
            error      <= (state_d == S_ERR);
            unique case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) count <= '0;
                end
                S_LEN: begin
                    if (accept) begin
                        len_q <= CW'(byte_in);
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q <= byte_in;
`endif
                    end
                end
                S_B0: begin
                    if (accept) begin
                        b0_q <= byte_in[3:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ byte_in;
`endif
                    end
                end
                S_B1: begin
                    if (accept) begin
                        b1_q <= byte_in;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ byte_in;
`endif
                    end
                end
                S_B2: begin
                    // Word address is the number of words already written
                    if (accept) begin
                        wr_addr <= count[AW-1:0];
                        wr_data <= {b0_q, b1_q, byte_in};
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q  <= csum_q ^ byte_in;
`endif
                    end
                end
                S_WRITE: count <= CW'(count + 1'b1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a monitor pops on wr_en.
module tb_imem_loader;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int EXP_BUSY = 10;
`else
    localparam int EXP_BUSY = 9;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [19:0]   wr_data;
    logic          busy;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [AW:0]   count;

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .cpu_hold(cpu_hold),
        .done(done), .error(error), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [19:0]   data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [19:0] words[$];
    int          checks = 0;
    int          failures = 0;
    int          busy_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected write
    always @(negedge clk) begin
        if (busy) busy_cycles++;
        if (wr_en) begin
            check("wr_byte_ready_low", 32'(byte_ready), 32'd0);
            check("wr_cpu_hold", 32'({busy, cpu_hold}), 32'd3);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wr actual addr=0x%0h data=0x%0h required none", wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                check("wr_data", 32'(wr_data), 32'(mon_e.data));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            checks++;
            failures++;
            $display("FAIL byte_timeout actual byte_ready=0 required 1 byte=0x%0h", b);
            byte_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (gap) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done || error) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(done || error)) begin
            checks++;
            failures++;
            $display("FAIL end_timeout actual done=0 error=0 required one set");
        end
    endtask

    task automatic run_load(input logic [7:0] len_b, input bit gap, input bit mid_start, input bit bad_cs);
        logic [7:0] cs;
        logic [7:0] b;
        wr_t        w;
        busy_cycles = 0;
        pulse_start();
        cs = len_b;
        send_byte(len_b, gap);
        for (int i = 0; i < words.size(); i++) begin
            b = {4'h0, words[i][19:16]};
            cs ^= b;
            send_byte(b, gap);
            b = words[i][15:8];
            cs ^= b;
            send_byte(b, gap);
            w.addr = AW'(i);
            w.data = words[i];
            exp_q.push_back(w);
            b = words[i][7:0];
            cs ^= b;
            send_byte(b, gap);
            if (mid_start && i == 0) pulse_start();
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (words.size() != 0) send_byte(bad_cs ? 8'h00 : cs, gap);
`else
        if (bad_cs) cs = 8'h00;
`endif
        byte_valid = 1'b0;
        wait_end();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_flags"}, 32'({byte_ready, wr_en, busy, cpu_hold, done, error}), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
    endtask

    task automatic check_ok(input string tag, input int n);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_busy"}, 32'({busy, cpu_hold}), 32'd0);
        check({tag, "_count"}, 32'(count), 32'(n));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_err(input string tag, input int n);
        check({tag, "_error"}, 32'(error), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_busy"}, 32'({busy, cpu_hold}), 32'd0);
        check({tag, "_count"}, 32'(count), 32'(n));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic two-word load, byte_valid held high
        words = '{20'h10022, 20'h23456};
        run_load(8'h02, 1'b0, 1'b0, 1'b0);
        check_ok("basic", 2);
        check("basic_busy_cycles", 32'(busy_cycles), 32'(EXP_BUSY));

        // Illegal lengths
        words = {};
        run_load(8'h00, 1'b0, 1'b0, 1'b0);
        check_err("len00", 0);
        run_load(8'h21, 1'b0, 1'b0, 1'b0);
        check_err("len21", 0);

        // Toggling byte_valid
        words = '{20'h10022, 20'h23456};
        run_load(8'h02, 1'b1, 1'b0, 1'b0);
        check_ok("toggle", 2);

        // Reset after the second byte of word 1
        busy_cycles = 0;
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        mon_e.addr = '0;
        mon_e.data = 20'h10022;
        exp_q.push_back(mon_e);
        send_byte(8'h22, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h34, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        byte_valid = 1'b0;
        @(negedge clk);
        check("midrst_pending", 32'(exp_q.size()), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_load(8'h02, 1'b0, 1'b0, 1'b0);
        check_ok("reload", 2);

        // start pulsed mid-load is ignored
        run_load(8'h02, 1'b0, 1'b1, 1'b0);
        check_ok("midstart", 2);

        // Full-depth load
        words = {};
        for (int i = 0; i < int'(DEPTH); i++) words.push_back({4'(i), 8'(i * 3), 8'(8'hA0 + i)});
        run_load(8'(DEPTH), 1'b0, 1'b0, 1'b0);
        check_ok("fulldepth", int'(DEPTH));
        check("fulldepth_last_addr", 32'(wr_addr), 32'(DEPTH - 1));

`ifdef IMEM_LOADER_CHECKSUM_EN
        words = '{20'hFFFFF};
        run_load(8'h01, 1'b0, 1'b0, 1'b0);
        check_ok("csum_good", 1);
        run_load(8'h01, 1'b0, 1'b0, 1'b1);
        check_err("csum_bad", 1);
        check("csum_bad_wr_data", 32'(wr_data), 32'h000FFFFF);
`endif

        repeat (3) @(negedge clk);
        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
